// File: rtl/core_ex_commit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_ex_commit_pkg                                                   |
// | Shared i2d core defines: data/flag/instruction types, buffer entry.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package core_ex_commit_pkg;

    localparam int c_reg_idx_w = 5;
    localparam int c_data_w    = 32;

    typedef logic [c_data_w-1:0]    data_t;
    typedef logic [c_reg_idx_w-1:0] reg_idx_t;

    typedef struct packed {
        logic cf;
        logic of;
        logic zf;
    } flag_t;

    typedef struct packed {
        logic [6:0] opcode;
        reg_idx_t   rd;
        reg_idx_t   rs1;
        reg_idx_t   rs2;
        logic [9:0] imm;
    } instr_t;

    typedef struct packed {
        logic     wen;
        reg_idx_t rd;
        data_t    data;
    } ex_entry_t;

    localparam flag_t c_flag_rst = '0;

    function automatic ex_entry_t make_entry(input logic wen, input reg_idx_t rd, input data_t data);
        ex_entry_t e;
        e.wen  = wen;
        e.rd   = rd;
        e.data = data;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_ex_commit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_ex_commit_if                                                    |
// | EX-side, write-back and forwarding signals of the commit stage.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface core_ex_commit_if;
    import core_ex_commit_pkg::*;

    logic     ex_valid;
    logic     ex_ready;
    logic     ex_wen;
    reg_idx_t ex_rd;
    logic     ex_fwe;
    data_t    alu_result;
    flag_t    alu_flag;
    logic     flush;
    flag_t    flag_q;

    logic     wb_valid;
    logic     wb_ready;
    logic     wb_wen;
    reg_idx_t wb_rd;
    data_t    wb_data;

    logic     fwd_valid;
    reg_idx_t fwd_rd;
    data_t    fwd_data;

    // Upstream/downstream environment around the stage
    modport master (
        output ex_valid, ex_wen, ex_rd, ex_fwe, alu_result, alu_flag, flush, wb_ready,
        input  ex_ready, flag_q, wb_valid, wb_wen, wb_rd, wb_data,
        input  fwd_valid, fwd_rd, fwd_data
    );

    // The commit stage itself
    modport slave (
        input  ex_valid, ex_wen, ex_rd, ex_fwe, alu_result, alu_flag, flush, wb_ready,
        output ex_ready, flag_q, wb_valid, wb_wen, wb_rd, wb_data,
        output fwd_valid, fwd_rd, fwd_data
    );

endinterface
`default_nettype wire

// File: rtl/core_ex_commit_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_skid_buf                                                        |
// | 2-entry in-order FIFO of ex_entry_t; slot 0 is always the head.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module core_skid_buf
    import core_ex_commit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire        clk,
    input  wire        rst,
    input  wire        i_push,
    input  wire        i_pop,
    input  wire        i_flush,
    input  ex_entry_t  i_entry,
    output logic [1:0] o_count,
    output logic       o_head_valid,
    output ex_entry_t  o_head,
    output ex_entry_t  o_tail
);

    generate
        if (DEPTH != 2) begin : g_depth_check
            $error("core_skid_buf supports DEPTH == 2 only");
        end
    endgenerate

    ex_entry_t r_slot0;
    ex_entry_t r_slot1;
    logic      r_vld0;
    logic      r_vld1;

    // Occupancy is contiguous: slot 1 is only valid when slot 0 is.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_vld0  <= 1'b0;
            r_vld1  <= 1'b0;
        end else if (i_flush) begin
            r_vld0 <= 1'b0;
            r_vld1 <= 1'b0;
        end else if (i_push && i_pop) begin
            if (r_vld1) begin
                r_slot0 <= r_slot1;
                r_slot1 <= i_entry;
            end else begin
                r_slot0 <= i_entry;
            end
        end else if (i_pop) begin
            r_slot0 <= r_slot1;
            r_vld0  <= r_vld1;
            r_vld1  <= 1'b0;
        end else if (i_push) begin
            if (!r_vld0) begin
                r_slot0 <= i_entry;
                r_vld0  <= 1'b1;
            end else begin
                r_slot1 <= i_entry;
                r_vld1  <= 1'b1;
            end
        end
    end

    assign o_count      = {1'b0, r_vld0} + {1'b0, r_vld1};
    assign o_head_valid = r_vld0;
    assign o_head       = r_slot0;
    assign o_tail       = r_vld1 ? r_slot1 : r_slot0;

endmodule
`default_nettype wire

// File: rtl/core_ex_commit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_ex_commit                                                       |
// | EX commit stage: flag register, result skid buffer, operand bypass.  |
// | Forwarding built only when I2D_EX_FWD_EN is defined.                 |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module core_ex_commit
    import core_ex_commit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire              clk,
    input  wire              rst,
    core_ex_commit_if.slave  bus
);

    logic      w_push;
    logic      w_pop;
    logic [1:0] w_count;
    logic      w_head_valid;
    ex_entry_t w_head;
    ex_entry_t w_tail;
    ex_entry_t w_in;
    flag_t     r_flag;

    // Ready is decoded from state only, so write-back never reaches EX combinationally.
    assign bus.ex_ready = !rst && (w_count < 2'(DEPTH));
    assign w_push       = bus.ex_valid && bus.ex_ready && !bus.flush;
    assign w_pop        = w_head_valid && bus.wb_ready && !bus.flush;
    assign w_in         = make_entry(bus.ex_wen, bus.ex_rd, bus.alu_result);

    core_skid_buf #(
        .DEPTH (DEPTH)
    ) u_skid_buf (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (bus.flush),
        .i_entry      (w_in),
        .o_count      (w_count),
        .o_head_valid (w_head_valid),
        .o_head       (w_head),
        .o_tail       (w_tail)
    );

    // Flags commit only with an accepted instruction and are never rolled back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag <= c_flag_rst;
        end else if (w_push && bus.ex_fwe) begin
            r_flag <= bus.alu_flag;
        end
    end

    assign bus.flag_q   = r_flag;
    assign bus.wb_valid = w_head_valid;
    assign bus.wb_wen   = w_head.wen;
    assign bus.wb_rd    = w_head.rd;
    assign bus.wb_data  = w_head.data;

`ifdef I2D_EX_FWD_EN
    logic     w_fwd_nxt_valid;
    reg_idx_t w_fwd_nxt_rd;
    data_t    w_fwd_nxt_data;
    logic     r_fwd_valid;
    reg_idx_t r_fwd_rd;
    data_t    r_fwd_data;

    // Look ahead to the post-edge buffer contents so the bypass outputs are registered.
    always_comb begin
        w_fwd_nxt_valid = 1'b0;
        w_fwd_nxt_rd    = '0;
        w_fwd_nxt_data  = '0;
        if (!w_pop) begin
            if (w_count != 2'd0 && w_head.wen) begin
                w_fwd_nxt_valid = 1'b1;
                w_fwd_nxt_rd    = w_head.rd;
                w_fwd_nxt_data  = w_head.data;
            end
            if (w_count != 2'd0 && w_tail.wen) begin
                w_fwd_nxt_valid = 1'b1;
                w_fwd_nxt_rd    = w_tail.rd;
                w_fwd_nxt_data  = w_tail.data;
            end
        end else if (w_count == 2'd2 && w_tail.wen) begin
            w_fwd_nxt_valid = 1'b1;
            w_fwd_nxt_rd    = w_tail.rd;
            w_fwd_nxt_data  = w_tail.data;
        end
        if (w_push && bus.ex_wen) begin
            w_fwd_nxt_valid = 1'b1;
            w_fwd_nxt_rd    = bus.ex_rd;
            w_fwd_nxt_data  = bus.alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_fwd_valid <= 1'b0;
            r_fwd_rd    <= '0;
            r_fwd_data  <= '0;
        end else begin
            r_fwd_valid <= w_fwd_nxt_valid;
            r_fwd_rd    <= w_fwd_nxt_rd;
            r_fwd_data  <= w_fwd_nxt_data;
        end
    end

    assign bus.fwd_valid = r_fwd_valid;
    assign bus.fwd_rd    = r_fwd_rd;
    assign bus.fwd_data  = r_fwd_data;
`else
    logic w_unused_tail;
    assign w_unused_tail = ^w_tail;
    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_rd    = '0;
    assign bus.fwd_data  = '0;
`endif

endmodule
`default_nettype wire

// File: doc/core_ex_commit.md
# core_ex_commit

Execute-commit stage sitting directly downstream of the ALU. It accepts one ALU result per cycle over a valid/ready handshake and commits flag updates to the architectural flag register, which it feeds back to the ALU as `flag_in`. Results are buffered in a 2-entry in-order skid buffer and handed to write-back over a second valid/ready handshake. It also exposes a forwarding port for operand bypass.

## Interface
- `DEPTH`, 2: skid buffer entries; only 2 is supported.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ex_valid`  in  1  ALU result valid this cycle.
- `ex_ready`  out  1  stage accepts this cycle.
- `ex_wen`  in  1  result writes a register.
- `ex_rd`  in  5  destination register index.
- `ex_fwe`  in  1  instruction updates flags.
- `alu_result`  in  `data_t` (32)  ALU result.
- `alu_flag`  in  `flag_t` (cf, of, zf)  ALU flags.
- `flush`  in  1  discard all buffered and incoming results.
- `flag_q`  out  `flag_t`  architectural flags, connected to ALU `flag_in`.
- `wb_valid`  out  1  head entry valid.
- `wb_ready`  in  1  write-back accepts.
- `wb_wen`, `wb_rd`, `wb_data`  out  1/5/32  head entry fields.
- `fwd_valid`, `fwd_rd`, `fwd_data`  out  1/5/32  youngest buffered register-writing result.

## Operation
- Accept: `ex_valid && ex_ready && !flush`. On accept, the entry {wen, rd, result} is pushed at the tail.
- Flag commit: on accept with `ex_fwe=1`, `flag_q <= alu_flag` (all three bits). With `ex_fwe=0`, `flag_q` holds.
- Flags are not rolled back by `flush`. Flags commit only on accept, so a flushed incoming instruction never writes them.
- `ex_ready = !rst && (count < 2)`. It does not depend on `wb_ready`, so there is no combinational path from write-back to EX.
- Pop: `wb_valid && wb_ready` removes the head. `wb_*` always show the head entry. `wb_valid = (count != 0)`.
- Simultaneous push and pop: `count` is unchanged and FIFO order is preserved. When `count==2`, push is impossible, so a pop frees a slot for the next cycle only.
- `flush`: `count <= 0` next cycle, and any same-cycle pop is ignored. `wb_valid` falls to 0 on the following cycle.
- Entries with `wen=0` still pass through to write-back, which keeps ordering simple; write-back ignores them.
- Forwarding: `fwd_*` reflect the youngest buffered entry with `wen=1`. `fwd_valid=0` when no such entry exists.
- Reset values: `count=0`, `flag_q={cf:0, of:0, zf:0}`, `wb_valid=0`, `fwd_valid=0`, `ex_ready=0` while `rst` is high. `wb_wen`, `wb_rd` and `wb_data` read 0. Reset mid-operation drops all entries.

## Timing
- Latency: accept in cycle N gives `wb_valid=1` in N+1 if the buffer was empty.
- Flag latency: accept in N gives new `flag_q` visible in N+1, so back-to-back ADD then ADDC sees the correct carry.
- Throughput: 1 per cycle while `wb_ready=1`.
- Backpressure: with `wb_ready=0`, two accepts fill the buffer and `ex_ready` drops the cycle after the second.
- All outputs except `ex_ready` are registered. `ex_ready` is decoded from the `count` register and `rst`.

## Configuration
- `I2D_EX_FWD_EN` defined: the forwarding logic is built as described above.
- `I2D_EX_FWD_EN` undefined: `fwd_valid`, `fwd_rd` and `fwd_data` are tied to 0 and no forwarding logic is synthesized.

## Structure
- `data_t`, `flag_t`, `instr_t` and the register-index width constant belong in the shared i2d core defines package.
- Add to that package an `ex_entry_t` struct {wen, rd, data}.
- Sub-module `core_skid_buf`: 2-entry FIFO of `ex_entry_t`, with push/pop/flush, `count`, head and tail-entry outputs.
- `core_ex_commit` adds the flag register, the handshake gating and the forwarding select.

## Test plan
- Reset, then one accept {wen=1, rd=3, data=0x0000_0005, fwe=1, flags cf=1} -> next cycle `wb_valid=1`, `wb_rd=3`, `wb_data=5`, `flag_q.cf=1`.
- Hold `wb_ready=0` and push 0xA then 0xB -> `ex_ready=0` after the second push. Then raise `wb_ready` -> 0xA pops, then 0xB, and `ex_ready` returns to 1.
- Accept with `fwe=0` and alu_flag=3'b111 while `flag_q=0` -> `flag_q` stays 0.
- Buffer holding 2 entries, plus `flush` with `ex_valid=1` and `fwe=1` -> `count=0` next cycle, no `wb_valid`, `flag_q` unchanged.
- Assert `rst` mid-stream with 2 entries buffered -> `wb_valid=0`, `flag_q=0` and `ex_ready=0` during reset. After reset `ex_ready=1` and no stale entries appear.
- With `I2D_EX_FWD_EN`: push {wen=1, rd=7, 0x1234} then {wen=0} -> `fwd_valid=1`, `fwd_rd=7`, `fwd_data=0x1234`. Without the macro, `fwd_valid` stays 0.
